oled_cmd_sequencer: RTL

- Upstream feeder for the SPI byte transmitter; produces its 10-bit {CS,DC,byte} word and START pulse, and consumes its DONE pulse.
- After a reset it runs the SSD1306 power-up sequence: hardware reset pulse, settle delay, then a fixed 25-byte init command list.
- It then streams full frames on request. Each frame is 8 pages × 128 columns, read from a synchronous framebuffer RAM.

---
 rtl/oled_pkg.sv | 44 ++++
 rtl/oled_init_rom.sv | 50 +++++
 rtl/oled_cmd_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
//------------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the SSD1306 command sequencer: FSM state encoding,
// SSD1306 command constants, SPI word field values and the init list length.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package oled_pkg;

  typedef enum logic [3:0] {
    ST_RES_LOW   = 4'd0,
    ST_RES_WAIT  = 4'd1,
    ST_INIT      = 4'd2,
    ST_WAIT_INIT = 4'd3,
    ST_IDLE      = 4'd4,
    ST_PAGE_CMD  = 4'd5,
    ST_WAIT_CMD  = 4'd6,
    ST_PIX_ADDR  = 4'd7,
    ST_PIX_SEND  = 4'd8,
    ST_WAIT_PIX  = 4'd9
  } state_t;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_COL_HI    = 8'h10;
  localparam logic [7:0] CMD_NOP       = 8'hE3;

  localparam int INIT_LEN = 25;

  localparam logic DC_CMD    = 1'b0;
  localparam logic DC_DATA   = 1'b1;
  localparam logic CS_ACTIVE = 1'b0;

  // Page preamble: set page address, then column pointer back to 0 (low/high nibble).
  function automatic logic [7:0] page_cmd_byte(input logic [1:0] step,
                                               input logic [2:0] page);
    case (step)
      2'd0:    return CMD_PAGE_BASE | {5'b0, page};
      2'd1:    return CMD_COL_LO;
      default: return CMD_COL_HI;
    endcase
  endfunction

endpackage

// File: rtl/oled_init_rom.sv
//------------------------------------------------------------------------------
// oled_init_rom
// Combinational SSD1306 power-up command list (25 bytes). Indices past the end
// of the list return the NOP command.
//   i_idx  : 5-bit list index
//   o_byte : command byte at that index
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module oled_init_rom
  import oled_pkg::*;
(
  input  logic [4:0] i_idx,
  output logic [7:0] o_byte
);

  always_comb begin
    // NOTE: default assignment first so every path assigns o_byte and no latch is inferred.
    o_byte = CMD_NOP;
    case (i_idx)
      5'd0:  o_byte = 8'hAE;  // display off
      5'd1:  o_byte = 8'hD5;  // clock divide
      5'd2:  o_byte = 8'h80;
      5'd3:  o_byte = 8'hA8;  // multiplex ratio
      5'd4:  o_byte = 8'h3F;
      5'd5:  o_byte = 8'hD3;  // display offset
      5'd6:  o_byte = 8'h00;
      5'd7:  o_byte = 8'h40;  // start line 0
      5'd8:  o_byte = 8'h8D;  // charge pump
      5'd9:  o_byte = 8'h14;
      5'd10: o_byte = 8'h20;  // addressing mode
      5'd11: o_byte = 8'h02;  // page addressing
      5'd12: o_byte = 8'hA1;  // segment remap
      5'd13: o_byte = 8'hC8;  // COM scan reversed
      5'd14: o_byte = 8'hDA;  // COM pins
      5'd15: o_byte = 8'h12;
      5'd16: o_byte = 8'h81;  // contrast
      5'd17: o_byte = 8'hCF;
      5'd18: o_byte = 8'hD9;  // precharge
      5'd19: o_byte = 8'hF1;
      5'd20: o_byte = 8'hDB;  // VCOMH
      5'd21: o_byte = 8'h40;
      5'd22: o_byte = 8'hA4;  // resume from RAM
      5'd23: o_byte = 8'hA6;  // normal polarity
      5'd24: o_byte = 8'hAF;  // display on
      default: o_byte = CMD_NOP;
    endcase
  end

endmodule

// File: rtl/oled_cmd_sequencer.sv
//------------------------------------------------------------------------------
// oled_cmd_sequencer
// Drives an SPI byte transmitter for an SSD1306 panel: hardware reset pulse,
// settle delay, 25-byte init list, then whole frames (PAGES x COLS bytes) read
// from a synchronous framebuffer on request.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   o_spi_data[9:0]   : {CS=0, DC, byte} word for the transmitter
//   o_spi_start       : one-cycle transfer request
//   i_spi_done        : one-cycle transfer completion
//   o_oled_res        : panel reset, active-low
//   o_pix_addr[9:0]   : framebuffer address {page, col}
//   i_pix_data[7:0]   : framebuffer data, one cycle after o_pix_addr
//   i_refresh         : frame request (level or pulse)
//   o_ready           : init complete
//   o_frame_done      : one-cycle pulse after the last byte of a frame
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module oled_cmd_sequencer
  import oled_pkg::*;
#(
  parameter int RES_LOW_CYCLES  = 250,
  parameter int RES_WAIT_CYCLES = 2500,
  parameter int PAGES           = 8,
  parameter int COLS            = 128
)(
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [9:0] o_spi_data,
  output logic       o_spi_start,
  input  logic       i_spi_done,
  output logic       o_oled_res,
  output logic [9:0] o_pix_addr,
  input  logic [7:0] i_pix_data,
  input  logic       i_refresh,
  output logic       o_ready,
  output logic       o_frame_done
);

  localparam int CNT_MAX = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] RES_LOW_LAST  = CNT_W'(RES_LOW_CYCLES - 1);
  // INIT spends one cycle before START appears, so the wait ends one count early
  // to place the first START exactly RES_WAIT_CYCLES after the reset rise.
  localparam logic [CNT_W-1:0] RES_WAIT_LAST = CNT_W'(RES_WAIT_CYCLES - 2);
  localparam logic [4:0]       INIT_LAST     = 5'(INIT_LEN - 1);
  localparam logic [2:0]       LAST_PAGE     = 3'(PAGES - 1);
  localparam logic [6:0]       LAST_COL      = 7'(COLS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_idx;
  logic [1:0]       r_cmd_step;
  logic [2:0]       r_page;
  logic [6:0]       r_col;
  logic             r_pending;
  logic [9:0]       r_spi_data;
  logic             r_spi_start;
  logic             r_oled_res;
  logic [9:0]       r_pix_addr;
  logic             r_ready;
  logic             r_frame_done;

  logic [7:0]       w_rom_byte;

  oled_init_rom u_init_rom (
    .i_idx  (r_idx),
    .o_byte (w_rom_byte)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_RES_LOW;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_cmd_step   <= '0;
      r_page       <= '0;
      r_col        <= '0;
      r_pending    <= 1'b0;
      r_spi_data   <= {CS_ACTIVE ^ 1'b1, 9'h000};
      r_spi_start  <= 1'b0;
      r_oled_res   <= 1'b0;
      r_pix_addr   <= '0;
      r_ready      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      // Pulse outputs fall back to 0 unless a state re-asserts them this cycle.
      r_spi_start  <= 1'b0;
      r_frame_done <= 1'b0;

      // A request seen while busy is remembered once and replayed from IDLE.
      if (i_refresh && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_RES_LOW: begin
          if (r_cnt == RES_LOW_LAST) begin
            r_cnt      <= '0;
            r_oled_res <= 1'b1;
            r_state    <= ST_RES_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RES_WAIT: begin
          if (r_cnt == RES_WAIT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_INIT: begin
          r_spi_data  <= {CS_ACTIVE, DC_CMD, w_rom_byte};
          r_spi_start <= 1'b1;
          r_state     <= ST_WAIT_INIT;
        end

        ST_WAIT_INIT: begin
          if (i_spi_done) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == INIT_LAST) begin
              r_ready <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_INIT;
            end
          end
        end

        ST_IDLE: begin
          if (i_refresh || r_pending) begin
            r_pending  <= 1'b0;
            r_page     <= '0;
            r_col      <= '0;
            r_cmd_step <= '0;
            r_state    <= ST_PAGE_CMD;
          end
        end

        ST_PAGE_CMD: begin
          r_spi_data  <= {CS_ACTIVE, DC_CMD, page_cmd_byte(r_cmd_step, r_page)};
          r_spi_start <= 1'b1;
          r_state     <= ST_WAIT_CMD;
        end

        ST_WAIT_CMD: begin
          if (i_spi_done) begin
            if (r_cmd_step == 2'd2) begin
              r_cmd_step <= '0;
              r_pix_addr <= {r_page, r_col};
              r_state    <= ST_PIX_ADDR;
            end else begin
              r_cmd_step <= r_cmd_step + 1'b1;
              r_state    <= ST_PAGE_CMD;
            end
          end
        end

        // Address was registered on entry; this cycle covers the RAM read latency.
        ST_PIX_ADDR: begin
          r_state <= ST_PIX_SEND;
        end

        ST_PIX_SEND: begin
          r_spi_data  <= {CS_ACTIVE, DC_DATA, i_pix_data};
          r_spi_start <= 1'b1;
          r_state     <= ST_WAIT_PIX;
        end

        ST_WAIT_PIX: begin
          if (i_spi_done) begin
            if (r_col != LAST_COL) begin
              r_col      <= r_col + 1'b1;
              r_pix_addr <= {r_page, r_col + 7'd1};
              r_state    <= ST_PIX_ADDR;
            end else begin
              r_col <= '0;
              if (r_page != LAST_PAGE) begin
                r_page  <= r_page + 1'b1;
                r_state <= ST_PAGE_CMD;
              end else begin
                r_frame_done <= 1'b1;
                r_state      <= ST_IDLE;
              end
            end
          end
        end

        default: r_state <= ST_RES_LOW;
      endcase
    end
  end

  assign o_spi_data   = r_spi_data;
  assign o_spi_start  = r_spi_start;
  assign o_oled_res   = r_oled_res;
  assign o_pix_addr   = r_pix_addr;
  assign o_ready      = r_ready;
  assign o_frame_done = r_frame_done;

endmodule
